// File: rtl/plot_sink.sv
// plot_sink: frame buffer fed by a pixel plotter, read back in raster order
// through a valid/ready handshake. Out-of-bounds plots are counted, not stored.
// Optional feature macro: PLOT_SINK_CLEAR_EN adds a 'clear' input that sweeps
// the whole frame to colour 0 from IDLE.
// rst_n is active-high and synchronous despite its name (legacy port name).
module plot_sink #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] vga_x,
    input  logic [6:0] vga_y,
    input  logic [2:0] vga_colour,
    input  logic       vga_plot,
    input  logic       start,
    input  logic       scan_ready,
    output logic [7:0] scan_x,
    output logic [6:0] scan_y,
    output logic [2:0] scan_colour,
    output logic       scan_valid,
    output logic       done,
    output logic [7:0] oob_count
`ifdef PLOT_SINK_CLEAR_EN
    ,
    input  logic       clear
`endif
);

    localparam int         DEPTH  = WIDTH * HEIGHT;
    localparam int         AW     = $clog2(DEPTH);
    localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
    localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        PRESENT,
        DONE
`ifdef PLOT_SINK_CLEAR_EN
        ,
        CLEAR
`endif
    } state_t;

    state_t        state, state_nx;
    logic [7:0]    cnt_x, cnt_x_nx, adv_x;
    logic [6:0]    cnt_y, cnt_y_nx, adv_y;
    logic          last_x, last_y, frame_end;

    logic [2:0]    mem [DEPTH];
    logic [2:0]    rd_data;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [2:0]    wr_data;
    logic          wr_en;
    logic          plot_inb;
    logic          plot_req;

`ifdef PLOT_SINK_CLEAR_EN
    logic          clr_end;
    logic          clr_pulse;
`endif

    assign plot_inb  = (vga_x <= X_LAST) && (vga_y <= Y_LAST);
    assign rd_addr   = AW'(cnt_y) * AW'(WIDTH) + AW'(cnt_x);

    // Raster advance shared by scan and sweep: x wraps into the next row
    assign last_x    = (cnt_x == X_LAST);
    assign last_y    = (cnt_y == Y_LAST);
    assign frame_end = last_x && last_y;
    assign adv_x     = last_x ? '0 : cnt_x + 8'd1;
    assign adv_y     = last_x ? (last_y ? '0 : cnt_y + 7'd1) : cnt_y;

    // Plot strobe qualification; the clear sweep owns the write port while it runs
    always_comb begin
        plot_req = vga_plot;
`ifdef PLOT_SINK_CLEAR_EN
        if (state == CLEAR) plot_req = 1'b0;
`endif
    end

    // Write port select: plotter normally, sweep address/zero during clear
    always_comb begin
        wr_en   = plot_req && plot_inb && !rst_n;
        wr_addr = AW'(vga_y) * AW'(WIDTH) + AW'(vga_x);
        wr_data = vga_colour;
`ifdef PLOT_SINK_CLEAR_EN
        if (state == CLEAR) begin
            wr_en   = !rst_n;
            wr_addr = rd_addr;
            wr_data = '0;
        end
`endif
    end

    // Frame memory write port (contents survive reset)
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Registered read port; a same-address write in this cycle is not yet visible
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rd_data <= '0;
        end else if (state == FETCH) begin
            rd_data <= mem[rd_addr];
        end
    end

    // Saturating count of rejected out-of-bounds plots
    always_ff @(posedge clk) begin
        if (rst_n) begin
            oob_count <= '0;
        end else if (plot_req && !plot_inb && (oob_count != 8'hFF)) begin
            oob_count <= oob_count + 8'd1;
        end
    end

    // State and raster counter registers
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
            cnt_x <= '0;
            cnt_y <= '0;
        end else begin
            state <= state_nx;
            cnt_x <= cnt_x_nx;
            cnt_y <= cnt_y_nx;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_nx = state;
        cnt_x_nx = cnt_x;
        cnt_y_nx = cnt_y;
`ifdef PLOT_SINK_CLEAR_EN
        clr_end  = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_x_nx = '0;
                cnt_y_nx = '0;
`ifdef PLOT_SINK_CLEAR_EN
                if (clear) state_nx = CLEAR;
                else if (start) state_nx = FETCH;
`else
                if (start) state_nx = FETCH;
`endif
            end
            FETCH: state_nx = PRESENT;
            PRESENT: begin
                if (scan_ready) begin
                    cnt_x_nx = adv_x;
                    cnt_y_nx = adv_y;
                    state_nx = frame_end ? DONE : FETCH;
                end
            end
            DONE: begin
                if (!start) state_nx = IDLE;
            end
`ifdef PLOT_SINK_CLEAR_EN
            CLEAR: begin
                cnt_x_nx = adv_x;
                cnt_y_nx = adv_y;
                if (frame_end) begin
                    state_nx = IDLE;
                    clr_end  = 1'b1;
                end
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

`ifdef PLOT_SINK_CLEAR_EN
    // One-cycle completion pulse after the last sweep write
    always_ff @(posedge clk) begin
        if (rst_n) clr_pulse <= 1'b0;
        else       clr_pulse <= clr_end;
    end
`endif

    // Handshake and status outputs decoded from state
    always_comb begin
        scan_valid = (state == PRESENT);
        done       = (state == DONE);
`ifdef PLOT_SINK_CLEAR_EN
        done       = done || clr_pulse;
`endif
    end

    assign scan_x      = cnt_x;
    assign scan_y      = cnt_y;
    assign scan_colour = rd_data;

endmodule

// File: doc/plot_sink.md
PLOT_SINK -- requirements
Module: plot_sink

Interface
REQ-001 Parameter: WIDTH, 160, number of pixel columns held.
REQ-002 Parameter: HEIGHT, 120, number of pixel rows held.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  one clock; reset is synchronous and active-high (rst_n = 1 resets on next rising edge of clk).
REQ-005 vga_x  input  8  plot column from the pixel writer.
REQ-006 vga_y  input  7  plot row from the pixel writer.
REQ-007 vga_colour  input  3  plot colour.
REQ-008 vga_plot  input  1  write strobe; one pixel written per high cycle.
REQ-009 start  input  1  level request to read the stored frame back in raster order.
REQ-010 scan_ready  input  1  downstream accepts current readback pixel.
REQ-011 scan_x  output  8  column of readback pixel.
REQ-012 scan_y  output  7  row of readback pixel.
REQ-013 scan_colour  output  3  stored colour at (scan_x, scan_y).
REQ-014 scan_valid  output  1  readback pixel valid.
REQ-015 done  output  1  readback complete.
REQ-016 oob_count  output  8  saturating count of rejected out-of-bounds plots.

Function
REQ-017 Storage: WIDTH*HEIGHT x 3-bit frame memory, address = y*WIDTH + x, one write port, one read port, read data one cycle after address.
REQ-018 Write: vga_plot=1 with vga_x<WIDTH and vga_y<HEIGHT writes vga_colour at that address that cycle; no backpressure; writes accepted in every state.
REQ-019 Out-of-bounds plot (vga_x>=WIDTH or vga_y>=HEIGHT): no write; oob_count +1, saturates at 255.
REQ-020 Same-cycle write and read of one address: read returns the pre-write value.
REQ-021 FSM states: IDLE, FETCH, PRESENT, DONE.
REQ-022 IDLE: scan_valid=0, done=0; start=1 -> FETCH with scan counters at (0,0).
REQ-023 FETCH: read issued at counter address; next cycle -> PRESENT (exactly one cycle).
REQ-024 PRESENT: scan_valid=1, scan_x/scan_y = counters, scan_colour = read data; outputs held stable while scan_ready=0.
REQ-025 PRESENT with scan_ready=1: pixel accepted; x wraps WIDTH-1 -> 0 incrementing y; accept of (WIDTH-1, HEIGHT-1) -> DONE, else -> FETCH.
REQ-026 Throughput: one pixel per two cycles maximum; full frame >= 2*WIDTH*HEIGHT cycles.
REQ-027 DONE: done=1, scan_valid=0; stays until start=0, then -> IDLE.
REQ-028 start dropped mid-scan: ignored; scan runs to DONE.
REQ-029 Counters never exceed WIDTH-1 / HEIGHT-1.

Reset
REQ-030 On reset: state IDLE, counters (0,0), scan_valid=0, done=0, scan_x=0, scan_y=0, scan_colour=0, oob_count=0.
REQ-031 Reset mid-scan aborts the scan; next start restarts at (0,0).
REQ-032 Frame memory contents are not cleared by reset; plots in the reset cycle are dropped.

Configuration
REQ-033 Macro PLOT_SINK_CLEAR_EN: when defined, input clear (1 bit) in IDLE sweeps all addresses writing colour 0, one per cycle, ignoring vga_plot and start until sweep ends, done pulsed 1 cycle at end.
REQ-034 Without PLOT_SINK_CLEAR_EN: no clear port, no sweep logic; behaviour exactly as REQ-017..REQ-032.

Verification
REQ-035 Reset, plot (5,7) colour 3, start, scan_ready=1 -> pixel (5,7) reads colour 3; DONE after 19200 accepts; done=1 until start=0.
REQ-036 Plot (160,0) and (0,120) -> no write, oob_count=2; 300 OOB plots -> oob_count=255.
REQ-037 scan_ready=0 for 10 cycles at (0,0) -> scan_valid=1, outputs unchanged; release -> next pixel (1,0).
REQ-038 Wrap: accept at (159,0) -> next scan_x=0, scan_y=1; accept at (159,119) -> DONE.
REQ-039 Reset asserted mid-scan at (40,2) -> next cycle scan_valid=0, done=0; restart begins at (0,0); earlier plots still read back.
REQ-040 Write colour 5 to (10,10) in same cycle FETCH reads (10,10) -> scan_colour = old value; second scan -> 5.
